// File: rtl/map_scanner.sv
// map_scanner: walks map memory 0..MAP_CELLS-1 and streams one cell per beat.
// Ports: m_clock/p_reset, scan_go/hold in; mem_rd/mem_addr/mem_data memory;
// map_block/now/in_do stream; scan_busy/scan_done/start_pos/goal_pos/map_err.
module map_scanner #(
  parameter int MAP_CELLS = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              scan_go,
  input  logic              hold,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        map_block,
  output logic [ADDR_W-1:0] now,
  output logic              in_do,
  output logic              scan_busy,
  output logic              scan_done,
  output logic [ADDR_W-1:0] start_pos,
  output logic [ADDR_W-1:0] goal_pos,
  output logic              map_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_EMIT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAP_CELLS - 1);

  localparam logic [7:0] MK_START = 8'h7F;
  localparam logic [7:0] MK_GOAL  = 8'h00;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        map_block_q, map_block_d;
  logic [ADDR_W-1:0] now_q, now_d;
  logic [1:0]        start_cnt_q, start_cnt_d;
  logic [1:0]        goal_cnt_q, goal_cnt_d;
  logic [ADDR_W-1:0] start_pos_q, start_pos_d;
  logic [ADDR_W-1:0] goal_pos_q, goal_pos_d;
  logic              map_err_q, map_err_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    map_block_d = map_block_q;
    now_d       = now_q;
    start_cnt_d = start_cnt_q;
    goal_cnt_d  = goal_cnt_q;
    start_pos_d = start_pos_q;
    goal_pos_d  = goal_pos_q;
    map_err_d   = map_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (scan_go) begin
          addr_d      = '0;
          start_cnt_d = '0;
          goal_cnt_d  = '0;
          start_pos_d = '0;
          goal_pos_d  = '0;
          map_err_d   = 1'b0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        map_block_d = mem_data;
        now_d       = addr_q;
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (!hold) begin
          // First marker wins the position; counters saturate at 3
          if (map_block_q == MK_START) begin
            if (start_cnt_q == 2'd0) start_pos_d = now_q;
            if (start_cnt_q != 2'd3) start_cnt_d = start_cnt_q + 2'd1;
          end
          if (map_block_q == MK_GOAL) begin
            if (goal_cnt_q == 2'd0) goal_pos_d = now_q;
            if (goal_cnt_q != 2'd3) goal_cnt_d = goal_cnt_q + 2'd1;
          end
          if (addr_q == LAST) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        map_err_d = !(start_cnt_q == 2'd1 && goal_cnt_q == 2'd1);
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      map_block_q <= '0;
      now_q       <= '0;
      start_cnt_q <= '0;
      goal_cnt_q  <= '0;
      start_pos_q <= '0;
      goal_pos_q  <= '0;
      map_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      map_block_q <= map_block_d;
      now_q       <= now_d;
      start_cnt_q <= start_cnt_d;
      goal_cnt_q  <= goal_cnt_d;
      start_pos_q <= start_pos_d;
      goal_pos_q  <= goal_pos_d;
      map_err_q   <= map_err_d;
    end
  end

  assign mem_rd    = (state_q == S_FETCH);
  assign mem_addr  = addr_q;
  assign map_block = map_block_q;
  assign now       = now_q;
  assign in_do     = (state_q == S_EMIT) && !hold;
  assign scan_busy = (state_q != S_IDLE);
  assign scan_done = (state_q == S_DONE);
  assign start_pos = start_pos_q;
  assign goal_pos  = goal_pos_q;
  assign map_err   = map_err_q;

endmodule

// File: tb/tb_map_scanner.sv
// tb_map_scanner: directed bench for map_scanner, 4-cell and 256-cell builds.
// Table of small maps plus reset, scan_go-held and full-size sequences.
module tb_map_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic p_reset;
  logic scan_go, hold, sel;

  logic       rd_a, rd_b;
  logic [7:0] addr_a, addr_b, md_a, md_b;
  logic [7:0] blk_a, blk_b, now_a, now_b;
  logic       ido_a, ido_b, busy_a, busy_b, done_a, done_b;
  logic [7:0] sp_a, sp_b, gp_a, gp_b;
  logic       err_a, err_b;

  logic [7:0] mem [256];

  map_scanner #(.MAP_CELLS(4), .ADDR_W(8)) dut_a (
    .m_clock(clk), .p_reset(p_reset),
    .scan_go(scan_go && !sel), .hold(hold && !sel),
    .mem_rd(rd_a), .mem_addr(addr_a), .mem_data(md_a),
    .map_block(blk_a), .now(now_a), .in_do(ido_a),
    .scan_busy(busy_a), .scan_done(done_a),
    .start_pos(sp_a), .goal_pos(gp_a), .map_err(err_a));

  map_scanner #(.MAP_CELLS(256), .ADDR_W(8)) dut_b (
    .m_clock(clk), .p_reset(p_reset),
    .scan_go(scan_go && sel), .hold(hold && sel),
    .mem_rd(rd_b), .mem_addr(addr_b), .mem_data(md_b),
    .map_block(blk_b), .now(now_b), .in_do(ido_b),
    .scan_busy(busy_b), .scan_done(done_b),
    .start_pos(sp_b), .goal_pos(gp_b), .map_err(err_b));

  always @(posedge clk) begin
    if (rd_a) md_a <= mem[addr_a];
    if (rd_b) md_b <= mem[addr_b];
  end

  wire       s_rd   = sel ? rd_b   : rd_a;
  wire [7:0] s_addr = sel ? addr_b : addr_a;
  wire [7:0] s_blk  = sel ? blk_b  : blk_a;
  wire [7:0] s_now  = sel ? now_b  : now_a;
  wire       s_ido  = sel ? ido_b  : ido_a;
  wire       s_busy = sel ? busy_b : busy_a;
  wire       s_done = sel ? done_b : done_a;
  wire [7:0] s_sp   = sel ? sp_b   : sp_a;
  wire [7:0] s_gp   = sel ? gp_b   : gp_a;
  wire       s_err  = sel ? err_b  : err_a;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_zero(input bit s, input string tag);
    sel = s;
    #1;
    chk({tag, " mem_rd"}, s_rd, 0);
    chk({tag, " mem_addr"}, s_addr, 0);
    chk({tag, " map_block"}, s_blk, 0);
    chk({tag, " now"}, s_now, 0);
    chk({tag, " in_do"}, s_ido, 0);
    chk({tag, " busy"}, s_busy, 0);
    chk({tag, " done"}, s_done, 0);
    chk({tag, " start_pos"}, s_sp, 0);
    chk({tag, " goal_pos"}, s_gp, 0);
    chk({tag, " map_err"}, s_err, 0);
  endtask

  // Expected emit cycle e starts at 3, slips by one per hold cycle seen
  // there, and moves to fire+3 after each beat; done comes one cycle
  // after the last beat.
  task automatic run_scan(input bit s, input int n, input int h0,
                          input int h1, input bit goh, input logic [7:0] esp,
                          input logic [7:0] egp, input bit eerr);
    int e, k, last;
    bit fin, exp_in;
    sel = s;
    @(posedge clk); #1 scan_go = 1'b1;
    e = 3; k = 0; fin = 0; last = 0;
    for (int c = 1; c <= 3 * n + 40 && !fin; c++) begin
      @(posedge clk); #1;
      scan_go = goh;
      hold = (c >= h0 && c <= h1);
      @(negedge clk);
      exp_in = (k < n && c == e && !hold);
      chk("in_do", s_ido, exp_in);
      chk("busy", s_busy, 1);
      if (k < n && c == e) begin
        chk("map_block", s_blk, mem[k]);
        chk("now", s_now, k);
        chk("mem_addr", s_addr, k);
        if (hold) e++;
        else begin k++; last = c; e = c + 3; end
      end
      if (s_done) begin
        chk("done_cycle", c, last + 1);
        chk("beats_at_done", k, n);
        fin = 1;
      end
    end
    if (!fin) chk("scan_done_timeout", 0, 1);
    // DONE has passed; if scan_go is still high it must be ignored there
    @(posedge clk); #1;
    scan_go = 1'b0; hold = 1'b0;
    @(negedge clk);
    chk("busy_after_done", s_busy, 0);
    chk("done_after_done", s_done, 0);
    chk("start_pos", s_sp, esp);
    chk("goal_pos", s_gp, egp);
    chk("map_err", s_err, eerr);
    chk("last_block", s_blk, mem[n-1]);
    chk("last_now", s_now, n - 1);
  endtask

  typedef struct {
    logic [0:3][7:0] m;
    int   h0, h1;
    bit   goh;
    logic [7:0] sp, gp;
    bit   err;
  } vec_t;

  vec_t tv [8];

  initial begin
    tv[0] = '{m: {8'h7F, 8'h20, 8'h00, 8'h41}, h0: 0, h1: -1, goh: 0,
              sp: 0, gp: 2, err: 0};
    tv[1] = '{m: {8'h7F, 8'h20, 8'h00, 8'h41}, h0: 6, h1: 8, goh: 0,
              sp: 0, gp: 2, err: 0};
    tv[2] = '{m: {8'h7F, 8'h7F, 8'h00, 8'h80}, h0: 0, h1: -1, goh: 0,
              sp: 0, gp: 2, err: 1};
    tv[3] = '{m: {8'h20, 8'hC0, 8'h41, 8'h00}, h0: 0, h1: -1, goh: 0,
              sp: 0, gp: 3, err: 1};
    tv[4] = '{m: {8'h00, 8'h7F, 8'h00, 8'h7F}, h0: 0, h1: -1, goh: 0,
              sp: 1, gp: 0, err: 1};
    tv[5] = '{m: {8'h41, 8'h00, 8'h20, 8'h7F}, h0: 0, h1: -1, goh: 1,
              sp: 3, gp: 1, err: 0};
    tv[6] = '{m: {8'h7F, 8'h7F, 8'h7F, 8'h7F}, h0: 0, h1: -1, goh: 0,
              sp: 0, gp: 0, err: 1};
    tv[7] = '{m: {8'h00, 8'h7F, 8'h60, 8'hA0}, h0: 3, h1: 4, goh: 0,
              sp: 1, gp: 0, err: 0};

    for (int i = 0; i < 256; i++) mem[i] = 8'h11;
    p_reset = 1'b1; scan_go = 1'b0; hold = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 p_reset = 1'b0;
    @(negedge clk);
    idle_zero(0, "rst_a");
    idle_zero(1, "rst_b");

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) mem[j] = tv[i].m[j];
      run_scan(0, 4, tv[i].h0, tv[i].h1, tv[i].goh,
               tv[i].sp, tv[i].gp, tv[i].err);
    end

    // Reset mid-scan: reset seen at the edge ending cycle 7
    for (int j = 0; j < 4; j++) mem[j] = tv[0].m[j];
    sel = 1'b0;
    @(posedge clk); #1 scan_go = 1'b1;
    @(posedge clk); #1 scan_go = 1'b0;
    repeat (5) @(posedge clk);
    #1 p_reset = 1'b1;
    @(posedge clk); #1 p_reset = 1'b0;
    @(negedge clk);
    idle_zero(0, "midrst");
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("midrst no done", s_done, 0);
      chk("midrst idle", s_busy, 0);
    end
    run_scan(0, 4, 0, -1, 0, 0, 2, 0);

    // Full size: start at 0, goal at 255, one hold mid-way
    for (int i = 0; i < 256; i++) mem[i] = 8'((i % 60) + 1);
    mem[0] = 8'h7F; mem[255] = 8'h00; mem[128] = 8'hC0;
    run_scan(1, 256, 300, 302, 0, 0, 255, 0);

    // Five starts must not wrap the saturating counter back to one
    for (int i = 0; i < 256; i++) mem[i] = 8'h33;
    for (int i = 0; i < 5; i++) mem[i] = 8'h7F;
    mem[5] = 8'h00;
    run_scan(1, 256, 0, -1, 0, 0, 5, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
